// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests through a req/ready
// handshake, fills the IF/ID register and buffers a returned word across decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        branch,
  input  logic [31:0] branchPC,
  input  logic        IF_flush,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_instruction,
  output logic        IFID_valid,
  output logic        fetch_stall
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hbuf_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;

  logic        adv;
  logic [31:0] pc_inc;
  logic [31:0] target;

  assign adv    = PCWrite & IFIDWrite;
  assign pc_inc = pc_q + 32'd4;
  assign target = branchPC & ~32'h0000_0003;

  assign imem_req         = (state_q == FETCH);
  assign imem_addr        = pc_q;
  assign fetch_stall      = imem_req & ~imem_ready;
  assign IFID_PC          = ifid_pc_q;
  assign IFID_instruction = ifid_instr_q;
  assign IFID_valid       = ifid_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hbuf_q       <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (branch) begin
      // Redirect kills any buffered word and any response accepted this cycle.
      state_q      <= FETCH;
      pc_q         <= target;
      hbuf_q       <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (adv) begin
              ifid_pc_q    <= pc_q;
              ifid_instr_q <= imem_rdata;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_inc;
            end else begin
              hbuf_q  <= imem_rdata;
              state_q <= HOLD;
            end
          end else if (IFIDWrite) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (adv) begin
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= hbuf_q;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_inc;
            state_q      <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
      // Flush only overrides the IF/ID write; PC, FSM and hbuf advance as usual.
      if (IF_flush) begin
        ifid_pc_q    <= '0;
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage plus a hand-written async-reset sequence.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IFIDWrite, branch, IF_flush, imem_ready;
  logic [31:0] branchPC, imem_rdata;
  logic        imem_req, IFID_valid, fetch_stall;
  logic [31:0] imem_addr, IFID_PC, IFID_instruction;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .reset            (reset),
    .PCWrite          (PCWrite),
    .IFIDWrite        (IFIDWrite),
    .branch           (branch),
    .branchPC         (branchPC),
    .IF_flush         (IF_flush),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .IFID_PC          (IFID_PC),
    .IFID_instruction (IFID_instruction),
    .IFID_valid       (IFID_valid),
    .fetch_stall      (fetch_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw, ifw, br;
    logic [31:0] bpc;
    logic        fl, rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall;
    logic [31:0] e_pc, e_ins;
    logic        e_v;
  } vec_t;

  function automatic vec_t mk(logic pcw, logic ifw, logic br, logic [31:0] bpc,
                              logic fl, logic rdy, logic [31:0] rdata,
                              logic e_req, logic [31:0] e_addr, logic e_stall,
                              logic [31:0] e_pc, logic [31:0] e_ins, logic e_v);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.br = br; v.bpc = bpc; v.fl = fl; v.rdy = rdy;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_v = e_v;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic v);
    chk({tag, ".ifid_pc"}, IFID_PC, pc);
    chk({tag, ".ifid_instr"}, IFID_instruction, ins);
    chk({tag, ".ifid_valid"}, {31'd0, IFID_valid}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr,
                         input logic stall);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, stall});
  endtask

  vec_t vecs[20];

  initial begin
    // pcw ifw br bpc fl rdy rdata | req addr stall | ifid pc, instr, valid
    vecs[0]  = mk(1,1,0,0,0,1,32'h00A00093, 1,32'h00,0, 32'h00,32'h00A00093,1);
    vecs[1]  = mk(1,1,0,0,0,0,32'h11111111, 1,32'h04,1, 32'h00,NOP,0);
    vecs[2]  = mk(1,1,0,0,0,0,32'h22222222, 1,32'h04,1, 32'h00,NOP,0);
    vecs[3]  = mk(1,1,0,0,0,1,32'h00100113, 1,32'h04,0, 32'h04,32'h00100113,1);
    vecs[4]  = mk(0,0,0,0,0,1,32'h002081B3, 1,32'h08,0, 32'h04,32'h00100113,1);
    vecs[5]  = mk(0,0,0,0,0,1,32'hDEADBEEF, 0,32'h08,0, 32'h04,32'h00100113,1);
    vecs[6]  = mk(0,0,0,0,0,1,32'hDEADBEEF, 0,32'h08,0, 32'h04,32'h00100113,1);
    vecs[7]  = mk(1,1,0,0,0,1,32'hBADBAD00, 0,32'h08,0, 32'h08,32'h002081B3,1);
    vecs[8]  = mk(1,1,0,0,0,1,32'h00000033, 1,32'h0C,0, 32'h0C,32'h00000033,1);
    vecs[9]  = mk(1,1,1,32'h40,1,1,32'h44444444, 1,32'h10,0, 32'h00,NOP,0);
    vecs[10] = mk(1,1,0,0,0,1,32'h55555555, 1,32'h40,0, 32'h40,32'h55555555,1);
    vecs[11] = mk(0,1,0,0,0,1,32'h66666666, 1,32'h44,0, 32'h40,32'h55555555,1);
    vecs[12] = mk(0,0,1,32'h83,0,1,32'h12345678, 0,32'h44,0, 32'h00,NOP,0);
    vecs[13] = mk(1,1,0,0,0,1,32'h77777777, 1,32'h80,0, 32'h80,32'h77777777,1);
    vecs[14] = mk(1,1,0,0,1,1,32'h88888888, 1,32'h84,0, 32'h00,NOP,0);
    vecs[15] = mk(1,1,0,0,0,1,32'h99999999, 1,32'h88,0, 32'h88,32'h99999999,1);
    vecs[16] = mk(1,0,0,0,0,0,32'hAAAA0000, 1,32'h8C,1, 32'h88,32'h99999999,1);
    vecs[17] = mk(1,1,1,32'hFFFFFFFE,0,0,32'hAAAA1111, 1,32'h8C,1, 32'h00,NOP,0);
    vecs[18] = mk(1,1,0,0,0,1,32'hAAAAAAAA, 1,32'hFFFFFFFC,0, 32'hFFFFFFFC,32'hAAAAAAAA,1);
    vecs[19] = mk(1,1,0,0,0,1,32'hBBBBBBBB, 1,32'h00,0, 32'h00,32'hBBBBBBBB,1);

    reset = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; branch = 1'b0; branchPC = '0;
    IF_flush = 1'b0; imem_ready = 1'b1; imem_rdata = '0;
    #1;
    chk_req("reset", 1'b1, 32'h0, 1'b0);
    chk_ifid("reset", 32'h0, NOP, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      PCWrite = vecs[i].pcw; IFIDWrite = vecs[i].ifw; branch = vecs[i].br;
      branchPC = vecs[i].bpc; IF_flush = vecs[i].fl; imem_ready = vecs[i].rdy;
      imem_rdata = vecs[i].rdata;
      #1;
      chk_req($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_stall);
      @(posedge clk);
      #1;
      chk_ifid($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_v);
      @(negedge clk);
    end

    // Park a word in hbuf, then reset mid-cycle: outputs must clear before any edge.
    PCWrite = 1'b0; IFIDWrite = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hCCCCCCCC;
    @(posedge clk);
    #2;
    chk("hold_before_reset.imem_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    #1;
    chk_req("async_reset", 1'b1, 32'h0, 1'b0);
    chk_ifid("async_reset", 32'h0, NOP, 1'b0);
    @(posedge clk);
    #1;
    chk_req("reset_held", 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1; imem_rdata = 32'hDDDDDDDD;
    #1;
    chk_req("post_reset", 1'b1, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_ifid("post_reset", 32'h0, 32'hDDDDDDDD, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
